// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead add/subtract with valid/ready flow control
// Define ADDER_FLAGS_EN to add the pipelined zero/neg/ovf result flags.
module pipelined_cla_adder #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout
`ifdef ADDER_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / GROUP;

  logic adv;

  // Returns {carry out, sum} for one slice: group G/P lookahead, then bit carries inside each group.
  function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                            input logic ci);
    logic [SW-1:0] g, p, c;
    logic [NG:0]   gc;
    logic          gg, gp, cc;
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    gc = '0;
    gc[0] = ci;
    for (int j = 0; j < NG; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        gp = gp & p[j*GROUP+i];
      end
      gc[j+1] = gg | (gp & gc[j]);
    end
    for (int j = 0; j < NG; j++) begin
      cc = gc[j];
      for (int i = 0; i < GROUP; i++) begin
        c[j*GROUP+i] = cc;
        cc = g[j*GROUP+i] | (p[j*GROUP+i] & cc);
      end
    end
    return {gc[NG], p ^ c};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = k * SW;
    localparam int HI = WIDTH - LO - SW;

    logic [WIDTH-LO-1:0] a_in, b_in;
    logic                ci, vin;
    logic [SW:0]         res;
    logic [LO+SW-1:0]    s_nx;
    logic [LO+SW-1:0]    s_q;
    logic                c_q, v_q;

    if (k == 0) begin : src
      assign a_in = A;
      assign b_in = B ^ {WIDTH{sub}};
      assign ci   = sub | cin;
      assign vin  = in_valid;
    end else begin : src
      assign a_in = stg[k-1].fwd.a_q;
      assign b_in = stg[k-1].fwd.b_q;
      assign ci   = stg[k-1].c_q;
      assign vin  = stg[k-1].v_q;
    end

    assign res = cla_slice(a_in[SW-1:0], b_in[SW-1:0], ci);

    if (k == 0) begin : lo
      assign s_nx = res[SW-1:0];
    end else begin : lo
      assign s_nx = {res[SW-1:0], stg[k-1].s_q};
    end

    // Data registers only load on valid beats, so bubbles leave the last result parked.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= vin;
        if (vin) begin
          c_q <= res[SW];
          s_q <= s_nx;
        end
      end
    end

    if (k < STAGES-1) begin : fwd
      logic [HI-1:0] a_q, b_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && vin) begin
          a_q <= a_in[WIDTH-LO-1:SW];
          b_q <= b_in[WIDTH-LO-1:SW];
        end
      end
    end

`ifdef ADDER_FLAGS_EN
    if (k == STAGES-1) begin : flg
      logic zero_q, neg_q, ovf_q;
      // Carry into the MSB is recovered as sum ^ a ^ b' at that bit.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (adv && vin) begin
          zero_q <= ~|s_nx;
          neg_q  <= s_nx[WIDTH-1];
          ovf_q  <= s_nx[WIDTH-1] ^ a_in[WIDTH-LO-1] ^ b_in[WIDTH-LO-1] ^ res[SW];
        end
      end
      assign zero = zero_q;
      assign neg  = neg_q;
      assign ovf  = ovf_q;
    end
`endif
  end

  assign out_valid = stg[STAGES-1].v_q;
  assign S         = stg[STAGES-1].s_q;
  assign cout      = stg[STAGES-1].c_q;
  assign adv       = ~out_valid | out_ready | ~rst_n;
  assign in_ready  = adv;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - directed vector bench for pipelined_cla_adder (WIDTH=16, STAGES=2)
module tb_pipelined_cla_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  wire          in_ready, out_valid, cout;
  wire  [W-1:0] s;
`ifdef ADDER_FLAGS_EN
  wire          zero, neg, ovf;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] s;
    logic         c, z, n, v;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(W), .GROUP(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .S(s), .cout(cout)
`ifdef ADDER_FLAGS_EN
    , .zero(zero), .neg(neg), .ovf(ovf)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int sent, got, stalls, stale;

    vecs[0]  = '{16'd120,  16'd7,    1'b1, 1'b0, 16'd128,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{16'd5,    16'd7,    1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{16'd7,    16'd5,    1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    step();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset S", 32'(s), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
`ifdef ADDER_FLAGS_EN
    check("reset flags", 32'({zero, neg, ovf}), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Table vectors, one beat at a time with a two-cycle latency check
    for (int i = 0; i < 12; i++) begin
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d early out_valid", i), 32'(out_valid), 32'd0);
      step();
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d S", i), 32'(s), 32'(vecs[i].s));
      check($sformatf("v%0d cout", i), 32'(cout), 32'(vecs[i].c));
`ifdef ADDER_FLAGS_EN
      check($sformatf("v%0d zero", i), 32'(zero), 32'(vecs[i].z));
      check($sformatf("v%0d neg", i), 32'(neg), 32'(vecs[i].n));
      check($sformatf("v%0d ovf", i), 32'(ovf), 32'(vecs[i].v));
`endif
    end
    step();
    step();

    // Backpressure: four back-to-back beats, out_ready low for cycles 2..4
    sent = 0; got = 0; stalls = 0;
    cin = 1'b0; sub = 1'b0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      out_ready = !(cyc >= 2 && cyc < 5);
      in_valid  = (sent < 4);
      a = W'(sent + 1);
      b = W'(sent + 1);
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        check("stall in_ready", 32'(in_ready), 32'd0);
        check("stall S", 32'(s), 32'(2 * (got + 1)));
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp result %0d", got), 32'(s), 32'(2 * (got + 1)));
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp delivered", 32'(got), 32'd4);
    check("bp stall cycles", 32'(stalls), 32'd3);
    check("bp no duplicate", 32'(out_valid), 32'd0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'd1; b = 16'd1;
    step();
    a = 16'd2; b = 16'd2;
    step();
    in_valid = 1'b0;
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("in-reset in_ready", 32'(in_ready), 32'd1);
    step();
    check("post-reset out_valid", 32'(out_valid), 32'd0);
    check("post-reset S", 32'(s), 32'd0);
    check("post-reset in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) stale++;
    end
    check("no stale result", 32'(stale), 32'd0);
    a = 16'd10; b = 16'd20; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("after-reset out_valid", 32'(out_valid), 32'd1);
    check("after-reset S", 32'(s), 32'd30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the 16-bit inter-nibble carry-lookahead adder.
- Splits a WIDTH-bit add/subtract into STAGES equal slices, one slice per clock stage.
- Inside each slice: GROUP-bit carry-lookahead blocks with group generate/propagate lookahead between groups.
- Valid/ready handshake with backpressure. Feeds the ALU datapath of the processor.

Parameters:
- WIDTH, 16, operand and sum width in bits; multiple of GROUP*STAGES.
- GROUP, 4, bits per lookahead group (nibble).
- STAGES, 2, pipeline stages; latency in cycles; 1 <= STAGES <= WIDTH/GROUP.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- cin  in  1  carry in; used only when sub=0.
- sub  in  1  0: S=A+B+cin; 1: S=A+~B+1 (cin ignored).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- S  out  WIDTH  sum/difference.
- cout  out  1  carry out of bit WIDTH-1; for sub, 1 means no borrow.

Behaviour:
- Reset (rst_n=0 at clk edge): all stage valid bits clear; out_valid=0, S=0, cout=0, and flags 0 when present. in_ready=1 during and after reset. Reset mid-operation discards every in-flight beat.
- Advance enable: adv = !out_valid | out_ready. in_ready = adv, combinational; no dependence on in_valid.
- The whole pipeline shifts as one unit when adv=1 and holds all registers when adv=0. Stall holds S/cout stable with out_valid asserted.
- Accept: beat captured when in_valid & in_ready. A beat accepted at edge n appears with out_valid=1 after edge n+STAGES-1 (STAGES cycles of latency), assuming no stall.
- Bubbles: when adv=1 and in_valid=0, an invalid slot enters the pipe. Back-to-back beats give a throughput of 1 per cycle.
- Stage k (0..STAGES-1) operates on bits [k*W/STAGES +: W/STAGES]:
  - Per bit: g=a&b', p=a^b', where b' = sub ? ~B : B.
  - Group G/P form per GROUP bits.
  - Carries between groups come from lookahead over group G/P and the stage carry-in.
  - The sum slice, carry-out and the not-yet-used upper operand bits are registered into stage k+1.
  - Stage 0 carry-in = sub ? 1 : cin.
- Lower sum slices are delay-matched so every bit of S for a beat leaves in the same cycle.
- Modular arithmetic: S = (A + b' + c0) mod 2^WIDTH; cout = bit WIDTH of the full sum.
- Simultaneous in/out: when out_valid & out_ready & in_valid all hold in one cycle, the output retires and the new beat is accepted in that same cycle.
- STAGES=1: a single registered CLA with 1-cycle latency; same handshake.

Optional Feature:
- Macro ADDER_FLAGS_EN.
- When defined, adds three output ports, each 1 bit and pipelined with S:
  - zero: S == 0.
  - neg: S[WIDTH-1].
  - ovf: signed overflow, i.e. carry into MSB XOR cout.
- Flag reset value 0; flags hold during stall.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=16, STAGES=2, A=120, B=7, cin=1, sub=0, out_ready=1 -> 2 cycles later out_valid=1, S=128, cout=0; flags: zero=0, neg=0, ovf=0.
- A=0xFFFF, B=0x0001, cin=0 -> S=0x0000, cout=1, zero=1. This beat also verifies carry across the stage boundary at bit 8.
- sub=1, A=5, B=7, cin=1 (ignored) -> S=0xFFFE, cout=0, neg=1. Then A=7, B=5 -> S=0x0002, cout=1.
- A=0x7FFF, B=0x0001, sub=0, cin=0 -> S=0x8000, cout=0, ovf=1, neg=1.
- Backpressure:
  - Setup: 4 back-to-back beats (1+1, 2+2, 3+3, 4+4), with out_ready held 0 from cycle 2 for 3 cycles.
  - Required: in_ready drops while out_valid=1 and out_ready=0; S holds at 2.
  - Then results 2, 4, 6, 8 are delivered in order with none lost or duplicated.
- Reset mid-flight:
  - Setup: pulse rst_n=0 for 1 cycle with 2 beats in the pipe.
  - Required: out_valid=0 and S=0 next cycle, no stale result ever emerges, and in_ready=1.
  - A new beat 10+20 yields S=30 after 2 cycles.
